// File: rtl/riscv_mpsoc_pkg.sv
// Shared BIU definitions: AHB burst-type codes, beat-count helper, arbiter owner states.
package riscv_mpsoc_pkg;

  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] WRAP4  = 3'd2;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] WRAP8  = 3'd4;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] WRAP16 = 3'd6;
  localparam logic [2:0] INCR16 = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} biu_owner_state_t;

  // Undefined-length INCR counts as one beat; the grant then ends on its first ack.
  function automatic logic [4:0] biu_type2beats(input logic [2:0] t);
    case (t)
      WRAP4,  INCR4:  return 5'd4;
      WRAP8,  INCR8:  return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo PORTS.
module riscv_rr_arbiter #(
  parameter int PORTS = 2,
  parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [PORTS-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic          found;
  logic [IW-1:0] p;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = '0;
    for (int i = 1; i <= PORTS; i++) begin
      p = IW'((int'(last) + i) % PORTS);
      if (!found && req[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = p;
      end
    end
  end

endmodule

// File: rtl/riscv_biu_arbiter.sv
// Shares one downstream BIU port between PORTS requesters; round-robin per
// transaction, grant held across bursts and locked sequences.
module riscv_biu_arbiter
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PLEN  = 64,
  parameter int PORTS = 2
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic [PORTS-1:0]      req_stb_i,
  output logic [PORTS-1:0]      req_stb_ack_o,
  output logic [PORTS-1:0]      req_d_ack_o,
  input  logic [PORTS*PLEN-1:0] req_adri_i,
  output logic [PLEN-1:0]       req_adro_o,
  input  logic [PORTS*3-1:0]    req_size_i,
  input  logic [PORTS*3-1:0]    req_type_i,
  input  logic [PORTS*3-1:0]    req_prot_i,
  input  logic [PORTS-1:0]      req_lock_i,
  input  logic [PORTS-1:0]      req_we_i,
  input  logic [PORTS*XLEN-1:0] req_d_i,
  output logic [XLEN-1:0]       req_q_o,
  output logic [PORTS-1:0]      req_ack_o,
  output logic [PORTS-1:0]      req_err_o,
  output logic                  biu_stb_o,
  output logic [PLEN-1:0]       biu_adri_o,
  output logic [2:0]            biu_size_o,
  output logic [2:0]            biu_type_o,
  output logic [2:0]            biu_prot_o,
  output logic                  biu_lock_o,
  output logic                  biu_we_o,
  output logic [XLEN-1:0]       biu_d_o,
  input  logic                  biu_stb_ack_i,
  input  logic                  biu_d_ack_i,
  input  logic [PLEN-1:0]       biu_adro_i,
  input  logic [XLEN-1:0]       biu_q_i,
  input  logic                  biu_ack_i,
  input  logic                  biu_err_i
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  biu_owner_state_t state, state_n;
  logic [IW-1:0]    owner, owner_n, last, last_n, sel, rr_idx;
  logic [4:0]       beats, beats_n;
  logic [PORTS-1:0] rr_grant;
  logic             any_req;

  logic [PORTS-1:0][PLEN-1:0] adr_a;
  logic [PORTS-1:0][XLEN-1:0] d_a;
  logic [PORTS-1:0][2:0]      size_a, type_a, prot_a;

  assign adr_a  = req_adri_i;
  assign d_a    = req_d_i;
  assign size_a = req_size_i;
  assign type_a = req_type_i;
  assign prot_a = req_prot_i;

  riscv_rr_arbiter #(.PORTS(PORTS), .IW(IW)) u_rr (
    .req   (req_stb_i),
    .last  (last),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  assign any_req = |req_stb_i;
  assign sel     = (state == IDLE) ? rr_idx : owner;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(PORTS - 1);
      beats <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      beats <= beats_n;
    end
  end

  always_comb begin
    state_n       = state;
    owner_n       = owner;
    last_n        = last;
    beats_n       = beats;
    biu_stb_o     = 1'b0;
    biu_lock_o    = 1'b0;
    biu_adri_o    = adr_a[sel];
    biu_size_o    = size_a[sel];
    biu_type_o    = type_a[sel];
    biu_prot_o    = prot_a[sel];
    biu_we_o      = req_we_i[sel];
    biu_d_o       = d_a[sel];
    req_stb_ack_o = '0;
    req_d_ack_o   = '0;
    req_ack_o     = '0;
    req_err_o     = '0;

    case (state)
      IDLE: begin
        biu_stb_o     = any_req;
        biu_lock_o    = any_req & req_lock_i[sel];
        req_stb_ack_o = rr_grant & {PORTS{biu_stb_ack_i}};
        if (any_req && biu_stb_ack_i) begin
          state_n = BUSY;
          owner_n = sel;
          last_n  = sel;
          beats_n = biu_type2beats(type_a[sel]);
        end
      end
      BUSY: begin
        biu_lock_o = req_lock_i[owner];
        // An error ends the burst even if it coincides with the final ack.
        if (biu_err_i || (biu_ack_i && beats == 5'd1)) begin
          beats_n = '0;
          state_n = req_lock_i[owner] ? LOCKED : IDLE;
        end else if (biu_ack_i) begin
          beats_n = beats - 5'd1;
        end
      end
      LOCKED: begin
        biu_stb_o              = req_stb_i[owner];
        biu_lock_o             = req_lock_i[owner];
        req_stb_ack_o[owner]   = req_stb_i[owner] & biu_stb_ack_i;
        if (req_stb_i[owner] && biu_stb_ack_i) begin
          state_n = BUSY;
          beats_n = biu_type2beats(type_a[owner]);
        end else if (!req_lock_i[owner] && !req_stb_i[owner]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE) begin
      req_d_ack_o[owner] = biu_d_ack_i;
      req_ack_o[owner]   = biu_ack_i;
      req_err_o[owner]   = biu_err_i;
    end

    if (!HRESETn) begin
      biu_stb_o     = 1'b0;
      biu_lock_o    = 1'b0;
      biu_adri_o    = '0;
      biu_size_o    = '0;
      biu_type_o    = '0;
      biu_prot_o    = '0;
      biu_we_o      = 1'b0;
      biu_d_o       = '0;
      req_stb_ack_o = '0;
      req_d_ack_o   = '0;
      req_ack_o     = '0;
      req_err_o     = '0;
    end
  end

  assign req_q_o    = HRESETn ? biu_q_i    : '0;
  assign req_adro_o = HRESETn ? biu_adro_i : '0;

endmodule
